// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution operand sequencer.
package conv_pkg;

  typedef enum logic {LOAD, RUN} seq_state_t;

  localparam int CONV_T = 14;

  function automatic int conv_p(input int n, input int m);
    return n - m + 1;
  endfunction

endpackage

// File: rtl/conv_operand_buf.sv
// Depth-D register file of signed T-bit operands: one synchronous write port, one combinational read port.
module conv_operand_buf #(
  parameter int T = 14,
  parameter int D = 16,
  localparam int AW = (D > 1) ? $clog2(D) : 1
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic signed [T-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_i,
  output logic signed [T-1:0] rdata_o
);

  logic signed [T-1:0] mem_q [D];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conv_operand_seq.sv
// Loads x (N samples) and f (M taps), then streams every (x[j+k], f[k]) pair of a valid
// convolution to the MAC through a single valid/ready output register.
module conv_operand_seq
  import conv_pkg::*;
#(
  parameter int T = CONV_T,
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] s_x_data,
  input  logic                s_x_valid,
  output logic                s_x_ready,
  input  logic signed [T-1:0] s_f_data,
  input  logic                s_f_valid,
  output logic                s_f_ready,
  output logic signed [T-1:0] mac_a,
  output logic signed [T-1:0] mac_b,
  output logic                mac_valid,
  input  logic                mac_ready,
  output logic                mac_clr,
  output logic                mac_last
);

  localparam int P   = conv_p(N, M);
  localparam int XCW = $clog2(N + 1);
  localparam int FCW = $clog2(M + 1);
  localparam int XAW = (N > 1) ? $clog2(N) : 1;
  localparam int FAW = (M > 1) ? $clog2(M) : 1;
  localparam logic [XCW-1:0] X_FULL = XCW'(N);
  localparam logic [FCW-1:0] F_FULL = FCW'(M);
  localparam logic [FCW-1:0] K_LAST = FCW'(M - 1);
  localparam logic [XCW-1:0] J_LAST = XCW'(P - 1);

  if (M < 1 || M > N) begin : g_param_check
    $error("conv_operand_seq: M must satisfy 1 <= M <= N");
  end

  seq_state_t          state_q, state_d;
  logic [XCW-1:0]      x_cnt_q, x_cnt_d, j_q, j_d;
  logic [FCW-1:0]      f_cnt_q, f_cnt_d, k_q, k_d;
  logic                mac_valid_q, mac_valid_d, mac_clr_q, mac_clr_d, mac_last_q, mac_last_d;
  logic signed [T-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic signed [T-1:0] x_rdata, f_rdata;
  logic                x_rdy, f_rdy, x_we, f_we;

  conv_operand_buf #(.T(T), .D(N)) u_x_buf (
    .clk_i   (clk),
    .we_i    (x_we),
    .waddr_i (XAW'(x_cnt_q)),
    .wdata_i (s_x_data),
    .raddr_i (XAW'(j_q) + XAW'(k_q)),
    .rdata_o (x_rdata)
  );

  conv_operand_buf #(.T(T), .D(M)) u_f_buf (
    .clk_i   (clk),
    .we_i    (f_we),
    .waddr_i (FAW'(f_cnt_q)),
    .wdata_i (s_f_data),
    .raddr_i (FAW'(k_q)),
    .rdata_o (f_rdata)
  );

  always_comb begin
    state_d     = state_q;
    x_cnt_d     = x_cnt_q;
    f_cnt_d     = f_cnt_q;
    j_d         = j_q;
    k_d         = k_q;
    x_rdy       = 1'b0;
    f_rdy       = 1'b0;
    x_we        = 1'b0;
    f_we        = 1'b0;
    mac_valid_d = mac_valid_q && !mac_ready;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    mac_clr_d   = mac_clr_q;
    mac_last_d  = mac_last_q;
    case (state_q)
      LOAD: begin
        x_rdy = (x_cnt_q < X_FULL);
        f_rdy = (f_cnt_q < F_FULL);
        x_we  = s_x_valid && x_rdy;
        f_we  = s_f_valid && f_rdy;
        if (x_we) x_cnt_d = x_cnt_q + XCW'(1);
        if (f_we) f_cnt_d = f_cnt_q + FCW'(1);
        if (x_cnt_q == X_FULL && f_cnt_q == F_FULL) state_d = RUN;
      end
      RUN: begin
        // A held pair keeps the register until its handshake completes.
        if (!mac_valid_q || mac_ready) begin
          mac_valid_d = 1'b1;
          mac_a_d     = x_rdata;
          mac_b_d     = f_rdata;
          mac_clr_d   = (k_q == '0);
          mac_last_d  = (k_q == K_LAST);
          if (k_q == K_LAST) begin
            k_d = '0;
            if (j_q == J_LAST) begin
              state_d = LOAD;
              x_cnt_d = '0;
              f_cnt_d = '0;
              j_d     = '0;
            end else begin
              j_d = j_q + XCW'(1);
            end
          end else begin
            k_d = k_q + FCW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      x_cnt_q     <= '0;
      f_cnt_q     <= '0;
      j_q         <= '0;
      k_q         <= '0;
      mac_valid_q <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_last_q  <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      x_cnt_q     <= x_cnt_d;
      f_cnt_q     <= f_cnt_d;
      j_q         <= j_d;
      k_q         <= k_d;
      mac_valid_q <= mac_valid_d;
      mac_clr_q   <= mac_clr_d;
      mac_last_q  <= mac_last_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
    end
  end

  assign s_x_ready = x_rdy;
  assign s_f_ready = f_rdy;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_valid = mac_valid_q;
  assign mac_clr   = mac_clr_q;
  assign mac_last  = mac_last_q;

endmodule

// File: tb/tb_conv_operand_seq.sv
// Randomized bench for conv_operand_seq: N=16/M=4 and N=M=16 instances checked against a pair-list model.
module tb_conv_operand_seq;

  localparam int T = 14;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic signed [T-1:0] x1_data = '0, f1_data = '0, x2_data = '0, f2_data = '0;
  logic x1_valid = 1'b0, f1_valid = 1'b0, x2_valid = 1'b0, f2_valid = 1'b0;
  logic x1_ready, f1_ready, x2_ready, f2_ready;
  logic signed [T-1:0] a1, b1, a2, b2;
  logic v1, c1, l1, v2, c2, l2;
  logic r1 = 1'b1, r2 = 1'b1;

  conv_operand_seq #(.T(T), .N(16), .M(4)) dut1 (
    .clk(clk), .reset(reset),
    .s_x_data(x1_data), .s_x_valid(x1_valid), .s_x_ready(x1_ready),
    .s_f_data(f1_data), .s_f_valid(f1_valid), .s_f_ready(f1_ready),
    .mac_a(a1), .mac_b(b1), .mac_valid(v1), .mac_ready(r1), .mac_clr(c1), .mac_last(l1)
  );

  conv_operand_seq #(.T(T), .N(16), .M(16)) dut2 (
    .clk(clk), .reset(reset),
    .s_x_data(x2_data), .s_x_valid(x2_valid), .s_x_ready(x2_ready),
    .s_f_data(f2_data), .s_f_valid(f2_valid), .s_f_ready(f2_ready),
    .mac_a(a2), .mac_b(b2), .mac_valid(v2), .mac_ready(r2), .mac_clr(c2), .mac_last(l2)
  );

  typedef struct { int a; int b; bit clr; bit last; } beat_t;
  beat_t exp1[$];
  beat_t exp2[$];

  int nchecks = 0, nerr = 0;
  int xv[16], fv[16];
  int beat_cnt[2], stall_cnt[2];
  int rec_a[2][64], rec_b[2][64];
  bit rec_clr[2][64], rec_last[2][64];
  bit prev_stall[2];
  int prev_a[2], prev_b[2];
  bit prev_clr[2], prev_last[2];
  int rmode = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    nchecks++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Expected pair list straight from the convolution definition.
  task automatic model_push(input int inst, input int n, input int m);
    beat_t e;
    for (int j = 0; j <= n - m; j++)
      for (int k = 0; k < m; k++) begin
        e.a = xv[j+k]; e.b = fv[k]; e.clr = (k == 0); e.last = (k == m - 1);
        if (inst == 0) exp1.push_back(e); else exp2.push_back(e);
      end
  endtask

  task automatic observe(input int i, input logic v, input logic r,
                         input logic signed [T-1:0] a, input logic signed [T-1:0] b,
                         input logic c, input logic l);
    beat_t e;
    bit empty;
    if (prev_stall[i]) begin
      chk($sformatf("dut%0d_hold_valid", i+1), v, 1);
      chk($sformatf("dut%0d_hold_a", i+1), a, prev_a[i]);
      chk($sformatf("dut%0d_hold_b", i+1), b, prev_b[i]);
      chk($sformatf("dut%0d_hold_clr", i+1), c, prev_clr[i]);
      chk($sformatf("dut%0d_hold_last", i+1), l, prev_last[i]);
    end
    prev_stall[i] = 1'b0;
    if (v) begin
      if (r) begin
        empty = (i == 0) ? (exp1.size() == 0) : (exp2.size() == 0);
        if (empty) chk($sformatf("dut%0d_extra_beat", i+1), beat_cnt[i], -1);
        else begin
          if (i == 0) e = exp1.pop_front(); else e = exp2.pop_front();
          chk($sformatf("dut%0d_beat%0d_a", i+1, beat_cnt[i]), a, e.a);
          chk($sformatf("dut%0d_beat%0d_b", i+1, beat_cnt[i]), b, e.b);
          chk($sformatf("dut%0d_beat%0d_clr", i+1, beat_cnt[i]), c, e.clr);
          chk($sformatf("dut%0d_beat%0d_last", i+1, beat_cnt[i]), l, e.last);
        end
        if (beat_cnt[i] < 64) begin
          rec_a[i][beat_cnt[i]] = a; rec_b[i][beat_cnt[i]] = b;
          rec_clr[i][beat_cnt[i]] = c; rec_last[i][beat_cnt[i]] = l;
        end
        beat_cnt[i]++;
      end else begin
        prev_stall[i] = 1'b1;
        prev_a[i] = a; prev_b[i] = b; prev_clr[i] = c; prev_last[i] = l;
        stall_cnt[i]++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
    end else begin
      observe(0, v1, r1, a1, b1, c1, l1);
      observe(1, v2, r2, a2, b2, c2, l2);
    end
  end

  always @(posedge clk) begin
    #1;
    case (rmode)
      1: begin r1 = ~r1; r2 = ~r2; end
      2: begin r1 = 1'($urandom_range(0, 1)); r2 = 1'($urandom_range(0, 1)); end
      default: begin r1 = 1'b1; r2 = 1'b1; end
    endcase
  end

  function automatic logic ready_of(input int inst, input bit is_f);
    if (inst == 0) return is_f ? f1_ready : x1_ready;
    return is_f ? f2_ready : x2_ready;
  endfunction

  task automatic drive(input int inst, input bit is_f, input int v, input logic vld);
    if (inst == 0 && !is_f) begin x1_data = T'(v); x1_valid = vld; end
    else if (inst == 0)     begin f1_data = T'(v); f1_valid = vld; end
    else if (!is_f)         begin x2_data = T'(v); x2_valid = vld; end
    else                    begin f2_data = T'(v); f2_valid = vld; end
  endtask

  task automatic send(input int inst, input bit is_f, input int v, input int gap);
    logic rdy;
    rdy = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    drive(inst, is_f, v, 1'b1);
    for (int n = 0; n < 100; n++) begin
      rdy = ready_of(inst, is_f);
      @(posedge clk); #1;
      if (rdy) break;
    end
    drive(inst, is_f, 0, 1'b0);
    if (!rdy) chk("load_handshake_timeout", 0, 1);
  endtask

  task automatic load(input int inst, input int n, input int m, input int gapmax);
    int xi = 0;
    int fi = 0;
    while (xi < n || fi < m) begin
      if (fi >= m || (xi < n && $urandom_range(0, 1) == 1)) begin
        send(inst, 1'b0, xv[xi], $urandom_range(0, gapmax)); xi++;
      end else begin
        send(inst, 1'b1, fv[fi], $urandom_range(0, gapmax)); fi++;
      end
    end
    model_push(inst, n, m);
  endtask

  task automatic wait_idle(input int inst);
    int qs;
    logic vv;
    for (int c = 0; c < 3000; c++) begin
      qs = (inst == 0) ? exp1.size() : exp2.size();
      vv = (inst == 0) ? v1 : v2;
      if (qs == 0 && !vv) break;
      @(posedge clk); #1;
    end
    qs = (inst == 0) ? exp1.size() : exp2.size();
    vv = (inst == 0) ? v1 : v2;
    chk($sformatf("dut%0d_pairs_outstanding", inst+1), qs, 0);
    chk($sformatf("dut%0d_valid_after_run", inst+1), vv, 0);
  endtask

  task automatic rand_vectors();
    for (int i = 0; i < 16; i++) begin
      xv[i] = int'($urandom_range(0, 16383)) - 8192;
      fv[i] = int'($urandom_range(0, 16383)) - 8192;
    end
  endtask

  initial begin
    int s, lat, run;

    // Reset
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_valid", v1, 0);
    chk("rst_clr", c1, 0);
    chk("rst_last", l1, 0);
    chk("rst_x_ready", x1_ready, 1);
    chk("rst_f_ready", f1_ready, 1);
    chk("rst_valid2", v2, 0);
    reset = 1'b0;

    // Basic run, x=1..16, f=1..4, ready always high
    for (int i = 0; i < 16; i++) xv[i] = i + 1;
    for (int k = 0; k < 4; k++) fv[k] = k + 1;
    s = 0;
    for (int k = 0; k < 4; k++) s += xv[k] * fv[k];
    chk("model_window0_sum", s, 30);
    beat_cnt[0] = 0; rmode = 0;
    load(0, 16, 4, 0);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (v1) begin lat = c; break; end
    end
    chk("first_pair_latency", lat, 2);
    run = (lat > 0) ? 1 : 0;
    for (int c = 0; c < 200 && lat > 0; c++) begin
      @(posedge clk); #1;
      if (v1) run++; else break;
    end
    chk("consecutive_valid", run, 52);
    wait_idle(0);
    chk("beat0_a", rec_a[0][0], 1);   chk("beat0_b", rec_b[0][0], 1);   chk("beat0_clr", rec_clr[0][0], 1);
    chk("beat3_a", rec_a[0][3], 4);   chk("beat3_b", rec_b[0][3], 4);   chk("beat3_last", rec_last[0][3], 1);
    chk("beat4_a", rec_a[0][4], 2);   chk("beat4_b", rec_b[0][4], 1);   chk("beat4_clr", rec_clr[0][4], 1);
    chk("beat51_a", rec_a[0][51], 16); chk("beat51_b", rec_b[0][51], 4); chk("beat51_last", rec_last[0][51], 1);
    s = 0;
    for (int k = 0; k < 4; k++) s += rec_a[0][k] * rec_b[0][k];
    chk("dut_window0_sum", s, 30);

    // Backpressure: ready toggles every cycle
    beat_cnt[0] = 0; stall_cnt[0] = 0; rmode = 1;
    load(0, 16, 4, 1);
    wait_idle(0);
    chk("bp_beats", beat_cnt[0], 52);
    chk("bp_stalls_seen", (stall_cnt[0] > 0) ? 1 : 0, 1);

    // Interleaved load: taps first, extra taps refused, x with gaps
    rmode = 0; beat_cnt[0] = 0;
    rand_vectors();
    for (int k = 0; k < 4; k++) send(0, 1'b1, fv[k], 0);
    for (int e = 0; e < 2; e++) begin
      f1_data = T'(-1); f1_valid = 1'b1;
      chk("f_ready_when_full", f1_ready, 0);
      @(posedge clk); #1;
    end
    f1_valid = 1'b0;
    for (int i = 0; i < 15; i++) send(0, 1'b0, xv[i], $urandom_range(0, 3));
    for (int c = 0; c < 3; c++) begin
      chk("no_run_before_x15", v1, 0);
      chk("x_ready_before_x15", x1_ready, 1);
      @(posedge clk); #1;
    end
    send(0, 1'b0, xv[15], 0);
    model_push(0, 16, 4);
    wait_idle(0);
    chk("interleave_beats", beat_cnt[0], 52);

    // Reset in the middle of a run, then a full reload
    rand_vectors();
    beat_cnt[0] = 0;
    load(0, 16, 4, 0);
    for (int c = 0; c < 500; c++) begin
      if (beat_cnt[0] >= 20) break;
      @(posedge clk); #1;
    end
    chk("reached_beat20", (beat_cnt[0] >= 20) ? 1 : 0, 1);
    reset = 1'b1;
    exp1.delete();
    @(posedge clk); #1;
    chk("midrun_rst_valid", v1, 0);
    chk("midrun_rst_x_ready", x1_ready, 1);
    chk("midrun_rst_f_ready", f1_ready, 1);
    reset = 1'b0;
    rand_vectors();
    beat_cnt[0] = 0;
    load(0, 16, 4, 1);
    wait_idle(0);
    chk("reload_beats", beat_cnt[0], 52);
    chk("reload_beat0_clr", rec_clr[0][0], 1);

    // M=N=16 with extreme operands
    for (int i = 0; i < 16; i++) begin xv[i] = -8192; fv[i] = -8192; end
    beat_cnt[1] = 0; rmode = 1;
    load(1, 16, 16, 1);
    wait_idle(1);
    chk("mn_beats", beat_cnt[1], 16);
    chk("mn_beat0_a", rec_a[1][0], -8192);
    chk("mn_beat15_b", rec_b[1][15], -8192);
    chk("mn_beat0_clr", rec_clr[1][0], 1);
    chk("mn_beat1_clr", rec_clr[1][1], 0);
    chk("mn_beat14_last", rec_last[1][14], 0);
    chk("mn_beat15_last", rec_last[1][15], 1);

    // Random data and random backpressure on both instances
    rmode = 2;
    for (int it = 0; it < 3; it++) begin
      rand_vectors();
      xv[0] = -8192; fv[0] = -8192; xv[15] = 8191; fv[3] = 8191;
      beat_cnt[0] = 0;
      load(0, 16, 4, 2);
      wait_idle(0);
      chk("rand_beats", beat_cnt[0], 52);
    end
    rand_vectors();
    beat_cnt[1] = 0;
    load(1, 16, 16, 2);
    wait_idle(1);
    chk("rand_mn_beats", beat_cnt[1], 16);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
